// File: rtl/ref_sample_buffer.sv
// ---------------------------------------------------------------------------
// ref_sample_buffer
//
// Multi-lane reference sample store for the CAF correlator front end.
// Holds buffer_length packed I/Q samples that are loaded at run time through
// a write port. Read requests return `lanes` consecutive samples per beat
// over a valid/ready address/data handshake with one cycle of latency.
//
// Configuration macro:
//   REF_BUF_WRAP_EN  defined   : lane addresses past the end of the buffer
//                                wrap back to the start.
//                    undefined : such lanes return zero and flag s_axi_rerr.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   s_axi_wvalid   write request
//   s_axi_wready   write accept (high from the first edge after reset)
//   s_axi_waddr    write address
//   s_axi_wdata    packed sample, I in the MSBs and Q in the LSBs
//   m_axi_arvalid  read request
//   m_axi_arready  read accept (combinational)
//   m_axi_araddr   base read address
//   s_axi_rvalid   read data valid
//   m_axi_rready   consumer ready
//   i              lane k at [k*i_bits +: i_bits], lane 0 in the LSBs
//   q              same lane packing as i
//   s_axi_rerr     beat contained an out-of-range lane
// ---------------------------------------------------------------------------
module ref_sample_buffer #(
    parameter int buffer_length = 10,
    parameter int index_bits    = 4,
    parameter int i_bits        = 12,
    parameter int q_bits        = 12,
    parameter int lanes         = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    input  logic [index_bits-1:0]     s_axi_waddr,
    input  logic [i_bits+q_bits-1:0]  s_axi_wdata,
    input  logic                      m_axi_arvalid,
    output logic                      m_axi_arready,
    input  logic [index_bits-1:0]     m_axi_araddr,
    output logic                      s_axi_rvalid,
    input  logic                      m_axi_rready,
    output logic [lanes*i_bits-1:0]   i,
    output logic [lanes*q_bits-1:0]   q,
    output logic                      s_axi_rerr
);

    localparam int SAMPLE_W = i_bits + q_bits;
    // One extra bit so base+lane never overflows before the range compare.
    localparam int ADDR_W = index_bits + 1;
    localparam logic [ADDR_W-1:0] LEN = ADDR_W'(buffer_length);

    logic [SAMPLE_W-1:0]     mem [buffer_length];

    logic                    write_in_range;
    logic                    read_fire;
    logic [ADDR_W-1:0]       base;
    logic [ADDR_W-1:0]       lane_addr;
    logic [SAMPLE_W-1:0]     sample;
    logic [lanes*i_bits-1:0] next_i;
    logic [lanes*q_bits-1:0] next_q;
    logic                    next_err;

    assign write_in_range = ({1'b0, s_axi_waddr} < LEN);
    assign m_axi_arready  = ~s_axi_rvalid | m_axi_rready;
    assign read_fire      = m_axi_arvalid & m_axi_arready;

    // Write accept comes up on the first edge after reset release and stays up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axi_wready <= 1'b0;
        end else begin
            s_axi_wready <= 1'b1;
        end
    end

    // Sample storage is not reset. Out-of-range writes are dropped. Because
    // the read path samples mem before this update lands, a same-edge read of
    // the written address returns the old contents.
    always_ff @(posedge clk) begin
        if (s_axi_wvalid && s_axi_wready && write_in_range) begin
            mem[s_axi_waddr] <= s_axi_wdata;
        end
    end

    // Gather the lanes for the requested base address. An out-of-range base
    // zeroes the whole beat and flags an error.
    always_comb begin
        next_i    = '0;
        next_q    = '0;
        next_err  = 1'b0;
        lane_addr = '0;
        sample    = '0;
        base      = {1'b0, m_axi_araddr};
        if (base >= LEN) begin
            next_err = 1'b1;
        end else begin
            for (int k = 0; k < lanes; k++) begin
                lane_addr = base + ADDR_W'(k);
`ifdef REF_BUF_WRAP_EN
                // base < LEN and k < LEN, so one subtraction always lands in range.
                if (lane_addr >= LEN) begin
                    lane_addr = lane_addr - LEN;
                end
                sample = mem[lane_addr[index_bits-1:0]];
                next_i[k*i_bits +: i_bits] = sample[SAMPLE_W-1 -: i_bits];
                next_q[k*q_bits +: q_bits] = sample[q_bits-1:0];
`else
                if (lane_addr >= LEN) begin
                    next_err = 1'b1;
                end else begin
                    sample = mem[lane_addr[index_bits-1:0]];
                    next_i[k*i_bits +: i_bits] = sample[SAMPLE_W-1 -: i_bits];
                    next_q[k*q_bits +: q_bits] = sample[q_bits-1:0];
                end
`endif
            end
        end
    end

    // Single output register. A new beat loads whenever a read fires; a
    // drained beat with no replacement only drops valid, leaving data as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axi_rvalid <= 1'b0;
            i            <= '0;
            q            <= '0;
            s_axi_rerr   <= 1'b0;
        end else if (read_fire) begin
            s_axi_rvalid <= 1'b1;
            i            <= next_i;
            q            <= next_q;
            s_axi_rerr   <= next_err;
        end else if (m_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ref_sample_buffer.sv
// ---------------------------------------------------------------------------
// tb_ref_sample_buffer
//
// Self-checking bench for ref_sample_buffer with buffer_length=10, lanes=4,
// 12-bit I and Q. Reads push their expected beat onto a scoreboard queue when
// they fire; an independent monitor compares every presented beat against the
// front of the queue and pops it when the consumer takes it. Expected beats
// come from a plain array model of the buffer contents.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ref_sample_buffer;

    localparam int BUF_LEN = 10;
    localparam int IDX_W   = 4;
    localparam int LANES   = 4;
    localparam int DW      = LANES * 12;

    typedef struct {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
        logic          err;
        bit            chk_data;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             s_axi_wvalid;
    logic             s_axi_wready;
    logic [IDX_W-1:0] s_axi_waddr;
    logic [23:0]      s_axi_wdata;
    logic             m_axi_arvalid;
    logic             m_axi_arready;
    logic [IDX_W-1:0] m_axi_araddr;
    logic             s_axi_rvalid;
    logic             m_axi_rready;
    logic [DW-1:0]    i;
    logic [DW-1:0]    q;
    logic             s_axi_rerr;

    int checks   = 0;
    int failures = 0;

    beat_t       sb[$];
    logic [11:0] mi [BUF_LEN];
    logic [11:0] mq [BUF_LEN];
    bit          mw [BUF_LEN];

    ref_sample_buffer #(
        .buffer_length(BUF_LEN),
        .index_bits   (IDX_W),
        .i_bits       (12),
        .q_bits       (12),
        .lanes        (LANES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_waddr  (s_axi_waddr),
        .s_axi_wdata  (s_axi_wdata),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_araddr (m_axi_araddr),
        .s_axi_rvalid (s_axi_rvalid),
        .m_axi_rready (m_axi_rready),
        .i            (i),
        .q            (q),
        .s_axi_rerr   (s_axi_rerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic comparison used by both the directed checks and the monitor.
    task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beat for a base address, straight from the lane rules.
    function automatic beat_t computeBeat(input int addr);
        beat_t b;
        b.i        = '0;
        b.q        = '0;
        b.err      = 1'b0;
        b.chk_data = 1'b1;
        if (addr >= BUF_LEN) begin
            b.err = 1'b1;
            return b;
        end
        for (int k = 0; k < LANES; k++) begin
            int a = addr + k;
            if (a >= BUF_LEN) begin
`ifdef REF_BUF_WRAP_EN
                a = a - BUF_LEN;
`else
                b.err = 1'b1;
                continue;
`endif
            end
            if (!mw[a]) b.chk_data = 1'b0;
            b.i[k*12 +: 12] = mi[a];
            b.q[k*12 +: 12] = mq[a];
        end
        return b;
    endfunction

    // Compare the presented beat against its expectation.
    task automatic checkOutput(input beat_t e);
        if (e.chk_data) begin
            checkVal("beat_i", i, e.i);
            checkVal("beat_q", q, e.q);
        end
        checkVal("beat_rerr", DW'(s_axi_rerr), DW'(e.err));
    endtask

    // Monitor: every cycle a beat is owed it must be presented and match; it
    // is retired only when the consumer is ready, so stalled data must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0) begin
                checks++;
                if (!s_axi_rvalid) begin
                    failures++;
                    $display("[TB] FAIL missing_beat rvalid=0 expected=1 at %0t", $time);
                end else begin
                    checkOutput(sb[0]);
                    if (m_axi_rready) void'(sb.pop_front());
                end
            end else if (s_axi_rvalid) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_beat rvalid=1 expected=0 at %0t", $time);
            end
        end
    end

    // One transaction slot: optional write and optional read issued together.
    // A stalled read is retried with the consumer forced ready.
    task automatic applyStimulus(input bit wr, input logic [IDX_W-1:0] wa, input logic [23:0] wd,
                                 input bit rd, input logic [IDX_W-1:0] ra);
        beat_t e;
        bit    done;
        bit    fire;
        done          = 1'b0;
        s_axi_wvalid  = wr;
        s_axi_waddr   = wa;
        s_axi_wdata   = wd;
        m_axi_arvalid = rd;
        m_axi_araddr  = ra;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            fire = rd && m_axi_arready;
            if (fire) e = computeBeat(int'(ra));
            @(posedge clk);
            if (fire) sb.push_back(e);
            if (n == 0 && wr && int'(wa) < BUF_LEN) begin
                mi[wa] = wd[23:12];
                mq[wa] = wd[11:0];
                mw[wa] = 1'b1;
            end
            #1;
            s_axi_wvalid = 1'b0;
            if (!rd || fire) done = 1'b1;
            else m_axi_rready = 1'b1;
        end
        m_axi_arvalid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL read_accept_timeout accepted=0 expected=1");
        end
    endtask

    initial begin
        beat_t e;
        rst_n         = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_waddr   = '0;
        s_axi_wdata   = '0;
        m_axi_arvalid = 1'b0;
        m_axi_araddr  = '0;
        m_axi_rready  = 1'b1;
        for (int n = 0; n < BUF_LEN; n++) mw[n] = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset_rvalid", DW'(s_axi_rvalid), '0);
        checkVal("reset_i", i, '0);
        checkVal("reset_q", q, '0);
        checkVal("reset_rerr", DW'(s_axi_rerr), '0);
        checkVal("reset_wready", DW'(s_axi_wready), '0);
        rst_n = 1'b1;
        #1;
        checkVal("wready_before_edge", DW'(s_axi_wready), '0);
        @(posedge clk);
        #1;
        checkVal("wready_after_edge", DW'(s_axi_wready), DW'(1));

        // Load I=n, Q=-n, then read address 2
        for (int n = 0; n < BUF_LEN; n++)
            applyStimulus(1'b1, IDX_W'(n), {12'(n), 12'(-n)}, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd2);

        // Lanes running past the end of the buffer
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd8);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd9);

        // Out-of-range base, dropped write, then confirm contents unchanged
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd12);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd15);
        applyStimulus(1'b1, 4'd11, 24'hABCDEF, 1'b0, '0);
        applyStimulus(1'b1, 4'd15, 24'h123456, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd0);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd6);

        // Back-pressure: consumer stalls for 3 cycles with a read pending
        @(posedge clk);
        #1;
        m_axi_rready = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd1);
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = 4'd6;
        repeat (3) begin
            @(negedge clk);
            checkVal("arready_stalled", DW'(m_axi_arready), '0);
            @(posedge clk);
            #1;
        end
        m_axi_rready = 1'b1;
        @(negedge clk);
        checkVal("arready_resume", DW'(m_axi_arready), DW'(1));
        e = computeBeat(6);
        @(posedge clk);
        sb.push_back(e);
        #1;
        m_axi_arvalid = 1'b0;

        // Read-before-write on the same address, then the new value
        applyStimulus(1'b1, 4'd3, {12'h7FF, 12'h123}, 1'b1, 4'd3);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd3);

        // Randomized mix of writes, reads and consumer back-pressure
        for (int n = 0; n < 200; n++) begin
            int op;
            op = int'($urandom_range(0, 2));
            m_axi_rready = ($urandom_range(0, 3) != 0);
            applyStimulus(op != 1, IDX_W'($urandom_range(0, 15)), 24'($urandom),
                          op != 0, IDX_W'($urandom_range(0, 15)));
        end

        // Reset while a beat is held
        m_axi_rready = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd5);
        #1;
        checkVal("rvalid_before_reset", DW'(s_axi_rvalid), DW'(1));
        rst_n = 1'b0;
        #1;
        checkVal("async_reset_rvalid", DW'(s_axi_rvalid), '0);
        checkVal("async_reset_i", i, '0);
        checkVal("async_reset_q", q, '0);
        checkVal("async_reset_rerr", DW'(s_axi_rerr), '0);
        checkVal("async_reset_wready", DW'(s_axi_wready), '0);
        sb.delete();
        for (int n = 0; n < BUF_LEN; n++) mw[n] = 1'b0;
        @(posedge clk);
        #2;
        rst_n        = 1'b1;
        m_axi_rready = 1'b1;
        #1;
        checkVal("wready_after_release", DW'(s_axi_wready), '0);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd0);
        @(negedge clk);
        checkVal("wready_restored", DW'(s_axi_wready), DW'(1));

        // Drain anything still owed
        m_axi_rready = 1'b1;
        for (int n = 0; n < 20 && sb.size() > 0; n++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain_timeout pending=%0d expected=0", sb.size());
        end
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
